lc3_mem_arbiter: RTL and testbench

// Sequences and shares the single LC3 memory port between instruction fetch and the data path
// (LD/LDR, ST/STR, and two-step LDI/STI). It grants one requester at a time, runs the 1- or
// 2-access sequence, handles variable-latency memory via mem_ready, and reports the phase on
// mem_state with the pipeline controller encoding.

---
 rtl/lc3_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC3 memory port between instruction fetch and the data path, sequencing
// one- and two-access (indirect) operations over variable-latency memory.
module lc3_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        if_flush,
   output logic        if_valid,
   output logic [15:0] if_rdata,
   input  logic        d_req,
   input  logic [1:0]  d_op,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic [1:0]  mem_state
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] IF_ACC = 3'd1;
   localparam logic [2:0] D_IND  = 3'd2;
   localparam logic [2:0] D_RD   = 3'd3;
   localparam logic [2:0] D_WR   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [1:0]    op_q, op_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   d_rdata_q, d_rdata_d;
   logic [15:0]   if_rdata_q, if_rdata_d;
   logic          data_q, data_d;
   logic          flushed_q, flushed_d;

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      d_rdata_d  = d_rdata_q;
      if_rdata_d = if_rdata_q;
      data_d     = data_q;
      flushed_d  = flushed_q;
      case (state_q)
         IDLE: begin
            flushed_d = 1'b0;
            // A pending fetch that has waited STARVE_LIMIT data grants takes priority.
            if (d_req && !(if_req && starve_q == LIMIT)) begin
               op_d     = d_op;
               addr_d   = d_addr;
               wdata_d  = d_wdata;
               data_d   = 1'b1;
               starve_d = if_req ? starve_q + SW'(1) : '0;
               if (d_op[0])      state_d = D_IND;
               else if (d_op[1]) state_d = D_WR;
               else              state_d = D_RD;
            end else if (if_req) begin
               addr_d   = if_addr;
               data_d   = 1'b0;
               starve_d = '0;
               state_d  = IF_ACC;
            end
         end
         IF_ACC: begin
            if (if_flush) flushed_d = 1'b1;
            if (mem_ready) begin
               if (!(flushed_q || if_flush)) if_rdata_d = mem_rdata;
               state_d = DONE;
            end
         end
         D_IND: begin
            if (mem_ready) begin
               addr_d  = mem_rdata;
               state_d = op_q[1] ? D_WR : D_RD;
            end
         end
         D_RD: begin
            if (mem_ready) begin
               d_rdata_d = mem_rdata;
               state_d   = DONE;
            end
         end
         D_WR: begin
            if (mem_ready) state_d = DONE;
         end
         DONE: begin
            flushed_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         op_q       <= 2'd0;
         addr_q     <= 16'h0000;
         wdata_q    <= 16'h0000;
         d_rdata_q  <= 16'h0000;
         if_rdata_q <= 16'h0000;
         data_q     <= 1'b0;
         flushed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         d_rdata_q  <= d_rdata_d;
         if_rdata_q <= if_rdata_d;
         data_q     <= data_d;
         flushed_q  <= flushed_d;
      end
   end

   always_comb begin
      mem_en    = (state_q == IF_ACC) || (state_q == D_IND) || (state_q == D_RD) ||
                  (state_q == D_WR);
      mem_we    = (state_q == D_WR);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      d_done    = (state_q == DONE) && data_q;
      if_valid  = (state_q == DONE) && !data_q && !flushed_q;
      d_rdata   = d_rdata_q;
      if_rdata  = if_rdata_q;
      case (state_q)
         D_RD:    mem_state = 2'd0;
         D_IND:   mem_state = 2'd1;
         D_WR:    mem_state = 2'd2;
         default: mem_state = 2'd3;
      endcase
   end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Randomized bench for lc3_mem_arbiter: a wait-state memory responder plus a reference model of
// LC3 load/store/indirect semantics, arbitration fairness and fetch flush behaviour.
module tb_lc3_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, if_valid, d_req, d_done;
   logic        mem_en, mem_we, mem_ready;
   logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  d_op, mem_state;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] exp_if_rdata = 16'h0000;
   int          wait_cfg = 0;
   int          wcnt = 0;

   logic [1:0]  acc_st[$];
   logic        acc_we[$];
   logic [15:0] acc_addr[$];
   logic [15:0] acc_wdata[$];
   logic [1:0]  cyc_st[$];

   always #5 clk = ~clk;

   lc3_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_valid(if_valid),
      .if_rdata(if_rdata),
      .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
      .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_state(mem_state)
   );

   // Memory responder: each access completes after wait_cfg wait cycles.
   always @(negedge clk) begin
      if (mem_en) begin
         cyc_st.push_back(mem_state);
         if (wcnt >= wait_cfg) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
            acc_st.push_back(mem_state);
            acc_we.push_back(mem_we);
            acc_addr.push_back(mem_addr);
            acc_wdata.push_back(mem_wdata);
            wcnt = 0;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            wcnt++;
         end
      end else begin
         mem_ready = 1'b0;
         wcnt = 0;
      end
   end

   task automatic clear_logs();
      acc_st.delete(); acc_we.delete(); acc_addr.delete(); acc_wdata.delete(); cyc_st.delete();
   endtask

   task automatic run_data(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat, output int ndone, output logic [15:0] rdata);
      @(negedge clk);
      d_req = 1'b1; d_op = op; d_addr = addr; d_wdata = wdata;
      lat = -1; ndone = 0; rdata = 16'h0000;
      @(posedge clk);
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (d_done) begin
            ndone++;
            if (lat < 0) begin lat = n; rdata = d_rdata; d_req = 1'b0; end
         end
         // Operands must already be latched; disturb them while the op runs.
         if (lat < 0) begin
            d_op = 2'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
         end
         if (lat >= 0 && n >= lat + 3) break;
      end
      d_req = 1'b0;
   endtask

   task automatic run_fetch(input logic [15:0] addr, output int lat, output int nvalid,
                            output logic [15:0] rdata);
      @(negedge clk);
      if_req = 1'b1; if_addr = addr; lat = -1; nvalid = 0; rdata = 16'h0000;
      @(posedge clk);
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (if_valid) begin
            nvalid++;
            if (lat < 0) begin lat = n; rdata = if_rdata; if_req = 1'b0; end
         end
         if (lat < 0) if_addr = 16'($urandom);
         if (lat >= 0 && n >= lat + 3) break;
      end
      if_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_req = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({mem_en, mem_we, if_valid, d_done} !== 4'b0000) begin
         miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {mem_en, mem_we, if_valid, d_done});
      end
      vectors++;
      if (mem_state !== 2'd3) begin
         miscompares++; $display("FAIL reset_state: got %0d want 3", mem_state);
      end
      vectors++;
      if ({mem_addr, mem_wdata, d_rdata, if_rdata} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, mem_wdata, d_rdata, if_rdata);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({mem_en, d_done, if_valid, mem_state} !== 5'b00011) begin
         miscompares++; $display("FAIL idle_no_req: got %b want 00011", {mem_en, d_done, if_valid, mem_state});
      end
   endtask

   task automatic test_ld_zero_wait();
      int lat, nd; logic [15:0] rd;
      mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
      wait_cfg = 0; clear_logs();
      run_data(2'd0, 16'h3000, 16'h0000, lat, nd, rd);
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL ld_latency: got %0d want 2", lat); end
      vectors++;
      if (nd !== 1) begin miscompares++; $display("FAIL ld_done_count: got %0d want 1", nd); end
      vectors++;
      if (rd !== 16'h1234) begin miscompares++; $display("FAIL ld_rdata: got %h want 1234", rd); end
      vectors++;
      if (cyc_st.size() !== 1 || cyc_st[0] !== 2'd0) begin
         miscompares++; $display("FAIL ld_mem_state: got %0d cycles want 1 cycle of state 0", cyc_st.size());
      end
   endtask

   task automatic test_ldi_waits();
      int lat, nd, bad; logic [15:0] rd;
      logic [1:0] exp_st[6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      mem[16'h3001] = 16'h4000; ref_mem[16'h3001] = 16'h4000;
      mem[16'h4000] = 16'hBEEF; ref_mem[16'h4000] = 16'hBEEF;
      wait_cfg = 2; clear_logs();
      run_data(2'd1, 16'h3001, 16'h0000, lat, nd, rd);
      bad = (cyc_st.size() == 6) ? 0 : 1;
      for (int i = 0; i < 6 && i < cyc_st.size(); i++) if (cyc_st[i] !== exp_st[i]) bad++;
      vectors++;
      if (bad !== 0) begin miscompares++; $display("FAIL ldi_state_seq: got %0d bad cycles want 0", bad); end
      vectors++;
      if (acc_addr.size() !== 2) begin
         miscompares++; $display("FAIL ldi_accesses: got %0d want 2", acc_addr.size());
      end else begin
         vectors++;
         if ({acc_addr[0], acc_addr[1]} !== 32'h3001_4000) begin
            miscompares++; $display("FAIL ldi_addrs: got %h %h want 3001 4000", acc_addr[0], acc_addr[1]);
         end
      end
      vectors++;
      if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL ldi_rdata: got %h want beef", rd); end
      vectors++;
      if (lat !== 7) begin miscompares++; $display("FAIL ldi_latency: got %0d want 7", lat); end
   endtask

   task automatic test_sti();
      int lat, nd; logic [15:0] rd;
      mem[16'h3002] = 16'h5000; ref_mem[16'h3002] = 16'h5000;
      mem[16'h5000] = 16'h0000; ref_mem[16'h5000] = 16'h00AA;
      wait_cfg = 0; clear_logs();
      run_data(2'd3, 16'h3002, 16'h00AA, lat, nd, rd);
      vectors++;
      if (nd !== 1) begin miscompares++; $display("FAIL sti_done_count: got %0d want 1", nd); end
      vectors++;
      if (lat !== 3) begin miscompares++; $display("FAIL sti_latency: got %0d want 3", lat); end
      vectors++;
      if (acc_addr.size() !== 2) begin
         miscompares++; $display("FAIL sti_accesses: got %0d want 2", acc_addr.size());
      end else begin
         vectors++;
         if ({acc_we[0], acc_st[0], acc_addr[0]} !== {1'b0, 2'd1, 16'h3002}) begin
            miscompares++; $display("FAIL sti_ptr_read: got we=%b st=%0d a=%h want 0 1 3002",
                                    acc_we[0], acc_st[0], acc_addr[0]);
         end
         vectors++;
         if ({acc_we[1], acc_st[1], acc_addr[1], acc_wdata[1]} !== {1'b1, 2'd2, 16'h5000, 16'h00AA}) begin
            miscompares++; $display("FAIL sti_write: got we=%b st=%0d a=%h d=%h want 1 2 5000 00aa",
                                    acc_we[1], acc_st[1], acc_addr[1], acc_wdata[1]);
         end
      end
      vectors++;
      if (mem[16'h5000] !== ref_mem[16'h5000]) begin
         miscompares++; $display("FAIL sti_memory: got %h want %h", mem[16'h5000], ref_mem[16'h5000]);
      end
   endtask

   task automatic test_random_data();
      int lat, nd, w, n_acc, exp_lat; logic [15:0] rd, addr, wdata, target; logic [1:0] op;
      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
         w = $urandom_range(0, 3);
         n_acc = op[0] ? 2 : 1;
         target = op[0] ? ref_mem[addr] : addr;
         exp_lat = 1 + n_acc * (w + 1);
         wait_cfg = w; clear_logs();
         run_data(op, addr, wdata, lat, nd, rd);
         vectors++;
         if (lat !== exp_lat || nd !== 1) begin
            miscompares++; $display("FAIL rnd_timing[%0d] op%0d: got lat=%0d done=%0d want lat=%0d done=1",
                                    t, op, lat, nd, exp_lat);
         end
         vectors++;
         if (acc_addr.size() !== n_acc || cyc_st.size() !== n_acc * (w + 1)) begin
            miscompares++; $display("FAIL rnd_accesses[%0d]: got %0d acc %0d cyc want %0d acc %0d cyc",
                                    t, acc_addr.size(), cyc_st.size(), n_acc, n_acc * (w + 1));
         end else begin
            vectors++;
            if (acc_addr[n_acc-1] !== target || acc_st[n_acc-1] !== (op[1] ? 2'd2 : 2'd0) ||
                acc_we[n_acc-1] !== op[1] || (op[0] && (acc_addr[0] !== addr || acc_st[0] !== 2'd1))) begin
               miscompares++; $display("FAIL rnd_access_seq[%0d] op%0d: got a=%h st=%0d want a=%h",
                                       t, op, acc_addr[n_acc-1], acc_st[n_acc-1], target);
            end
            if (op[1]) begin
               vectors++;
               if (acc_wdata[n_acc-1] !== wdata) begin
                  miscompares++; $display("FAIL rnd_wdata[%0d]: got %h want %h", t, acc_wdata[n_acc-1], wdata);
               end
            end
         end
         if (op[1]) ref_mem[target] = wdata;
         else begin
            vectors++;
            if (rd !== ref_mem[target]) begin
               miscompares++; $display("FAIL rnd_rdata[%0d] op%0d: got %h want %h", t, op, rd, ref_mem[target]);
            end
         end
      end
   endtask

   task automatic test_random_fetch();
      int lat, nv, w; logic [15:0] rd, addr;
      for (int t = 0; t < 12; t++) begin
         addr = 16'($urandom); w = $urandom_range(0, 3);
         wait_cfg = w; clear_logs();
         run_fetch(addr, lat, nv, rd);
         vectors++;
         if (lat !== 2 + w || nv !== 1) begin
            miscompares++; $display("FAIL fetch_timing[%0d]: got lat=%0d valid=%0d want lat=%0d valid=1",
                                    t, lat, nv, 2 + w);
         end
         vectors++;
         if (rd !== ref_mem[addr] || acc_addr.size() !== 1 || cyc_st.size() !== w + 1) begin
            miscompares++; $display("FAIL fetch_data[%0d]: got %h (%0d acc) want %h", t, rd,
                                    acc_addr.size(), ref_mem[addr]);
         end
         exp_if_rdata = ref_mem[addr];
      end
   endtask

   task automatic test_contention();
      int n_done = 0, n_valid = 0, bad = 0, n_d = 0, n_f = 0;
      wait_cfg = 0; clear_logs();
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0100; d_req = 1'b1; d_op = 2'd0; d_addr = 16'h2000;
      for (int n = 0; n < 120 && acc_st.size() < 15; n++) begin
         @(negedge clk);
         if (d_done) n_done++;
         if (if_valid) n_valid++;
         d_addr = 16'($urandom);
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (d_done) n_done++;
         if (if_valid) n_valid++;
      end
      // Four data grants, then the starved fetch, repeating.
      for (int i = 0; i < 15 && i < acc_st.size(); i++)
         if (acc_st[i] !== ((i % 5 == 4) ? 2'd3 : 2'd0)) bad++;
      vectors++;
      if (acc_st.size() < 15 || bad !== 0) begin
         miscompares++; $display("FAIL starve_order: got %0d grants %0d out of order want 15 and 0",
                                 acc_st.size(), bad);
      end
      foreach (acc_st[i]) if (acc_st[i] == 2'd3) n_f++; else n_d++;
      vectors++;
      if (n_done !== n_d || n_valid !== n_f) begin
         miscompares++; $display("FAIL starve_pulses: got done=%0d valid=%0d want %0d %0d",
                                 n_done, n_valid, n_d, n_f);
      end
      exp_if_rdata = ref_mem[16'h0100];
   endtask

   task automatic test_flush();
      int nv = 0; logic [15:0] got = 16'h0000;
      wait_cfg = 2; clear_logs();
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0010;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      if_flush = 1'b1; if_addr = 16'h0020;
      @(negedge clk);
      if_flush = 1'b0;
      @(negedge clk);
      vectors++;
      if (if_valid !== 1'b0 || if_rdata !== exp_if_rdata) begin
         miscompares++; $display("FAIL flush_done: got valid=%b rdata=%h want 0 %h", if_valid, if_rdata,
                                 exp_if_rdata);
      end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (if_valid) begin nv++; if (nv == 1) begin got = if_rdata; if_req = 1'b0; end end
      end
      if_req = 1'b0;
      vectors++;
      if (nv !== 1 || got !== ref_mem[16'h0020]) begin
         miscompares++; $display("FAIL flush_refetch: got %0d valid rdata=%h want 1 %h", nv, got,
                                 ref_mem[16'h0020]);
      end
      vectors++;
      if (acc_addr.size() !== 2 || acc_addr[0] !== 16'h0010 || acc_addr[acc_addr.size()-1] !== 16'h0020) begin
         miscompares++; $display("FAIL flush_accesses: got %0d accesses want 0010 then 0020", acc_addr.size());
      end
      exp_if_rdata = ref_mem[16'h0020];
   endtask

   task automatic test_reset_mid_write();
      int n_done = 0, n_en = 0, lat, nd; logic [15:0] rd;
      wait_cfg = 1000; clear_logs();
      @(negedge clk);
      d_req = 1'b1; d_op = 2'd2; d_addr = 16'h6000; d_wdata = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({mem_en, mem_we, mem_state} !== 4'b1110) begin
         miscompares++; $display("FAIL wr_active: got %b want 1110", {mem_en, mem_we, mem_state});
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({mem_en, mem_we, mem_state} !== 4'b0011) begin
         miscompares++; $display("FAIL async_reset: got %b want 0011", {mem_en, mem_we, mem_state});
      end
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (d_done) n_done++;
         if (mem_en) n_en++;
      end
      vectors++;
      if (n_done !== 0 || n_en !== 0 || mem[16'h6000] !== ref_mem[16'h6000]) begin
         miscompares++; $display("FAIL reset_no_done: got done=%0d en=%0d want 0 0", n_done, n_en);
      end
      wait_cfg = 0;
      run_data(2'd0, 16'h6001, 16'h0000, lat, nd, rd);
      vectors++;
      if (lat !== 2 || nd !== 1 || rd !== ref_mem[16'h6001]) begin
         miscompares++; $display("FAIL reset_resume: got lat=%0d done=%0d rdata=%h want 2 1 %h",
                                 lat, nd, rd, ref_mem[16'h6001]);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      mem_ready = 1'b0; mem_rdata = 16'h0000;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_ld_zero_wait();
      test_ldi_waits();
      test_sti();
      test_random_data();
      test_random_fetch();
      test_contention();
      test_flush();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
